// File: rtl/traffic_pkg.sv
// traffic_pkg
// Shared definitions for the intersection phase sequencer and the light
// decoder: the 2-bit phase codes, the phase timer width and small helpers.
package traffic_pkg;

    // Width of the per-phase tick countdown (durations 1..63)
    localparam int TIMER_W = 6;

    // Phase codes; the light decoder decodes the same values
    typedef enum logic [1:0] {
        ST_MG = 2'd0,   // main green
        ST_MY = 2'd1,   // main yellow
        ST_CG = 2'd2,   // country green
        ST_CY = 2'd3    // country yellow
    } phase_e;

    // Fixed rotation MG -> MY -> CG -> CY -> MG
    function automatic phase_e next_phase(input phase_e ph);
        case (ph)
            ST_MG:   return ST_MY;
            ST_MY:   return ST_CG;
            ST_CG:   return ST_CY;
            ST_CY:   return ST_MG;
            default: return ST_MG;
        endcase
    endfunction

    // Convert an integer duration parameter to a timer value
    function automatic logic [TIMER_W-1:0] to_timer(input int ticks);
        return TIMER_W'(ticks);
    endfunction

endpackage

// File: rtl/traffic_sequencer_if.sv
// traffic_sequencer_if
// Signal bundle between the phase sequencer and its environment.
//   c_car         : country-road vehicle sensor (asynchronous level)
//   hold          : synchronous maintenance freeze
//   current_state : phase code (traffic_pkg::phase_e values)
//   remain        : ticks left in the phase, 0 = MG waiting for a car
//   tick          : one-cycle pulse per 1 s tick
// master = sequencer side, slave = sensor/decoder side.
interface traffic_sequencer_if;

    logic                            c_car;
    logic                            hold;
    logic [1:0]                      current_state;
    logic [traffic_pkg::TIMER_W-1:0] remain;
    logic                            tick;

    modport master (
        input  c_car,
        input  hold,
        output current_state,
        output remain,
        output tick
    );

    modport slave (
        output c_car,
        output hold,
        input  current_state,
        input  remain,
        input  tick
    );

endinterface

// File: rtl/tick_gen.sv
// tick_gen
// Prescaler producing the internal 1 s tick strobe.
//   clk    : system clock
//   rst_n  : asynchronous active-low reset
//   hold   : freezes the count; a terminal count under hold gives no tick
//   tick_i : strobe, high for one cycle when the count wraps
// Parameter TICK_DIV: clk cycles per tick (>= 2).
module tick_gen #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic hold,
    output logic tick_i
);

    localparam int              CNT_W    = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    if (TICK_DIV < 2) begin : g_bad_div
        $error("tick_gen: TICK_DIV must be at least 2");
    end

    logic [CNT_W-1:0] cnt_r;
    logic             tick_s;

    // Terminal count strobe; hold suppresses it so the phase FSM also freezes
    always_comb begin
        tick_s = (cnt_r == CNT_LAST) && !hold;
    end

    assign tick_i = tick_s;

    // Prescaler counter: wraps on the strobe, frozen while hold is high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (hold) begin
            cnt_r <= cnt_r;
        end else if (tick_s) begin
            cnt_r <= {CNT_W{1'b0}};
        end else begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

endmodule

// File: rtl/traffic_sequencer.sv
// traffic_sequencer
// Phase sequencer for the main-road / country-road intersection.
// Main road stays green until a country car waits and the minimum green has
// elapsed; country green ends at its maximum, or early once the road clears.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : traffic_sequencer_if.master (c_car, hold in; current_state,
//           remain, tick out; all outputs registered)
// Parameters (ticks unless noted): TICK_DIV (clk per tick), MG_MIN, CG_MAX,
// CG_MIN, Y_TIME.
module traffic_sequencer
    import traffic_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000,
    parameter int MG_MIN   = 20,
    parameter int CG_MAX   = 15,
    parameter int CG_MIN   = 5,
    parameter int Y_TIME   = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    traffic_sequencer_if.master  bus
);

    if (MG_MIN < 1 || MG_MIN > 63) begin : g_bad_mg
        $error("traffic_sequencer: MG_MIN out of range 1..63");
    end
    if (CG_MAX < 1 || CG_MAX > 63) begin : g_bad_cgmax
        $error("traffic_sequencer: CG_MAX out of range 1..63");
    end
    if (CG_MIN < 1 || CG_MIN > 63 || CG_MIN > CG_MAX) begin : g_bad_cgmin
        $error("traffic_sequencer: CG_MIN out of range 1..CG_MAX");
    end
    if (Y_TIME < 1 || Y_TIME > 63) begin : g_bad_y
        $error("traffic_sequencer: Y_TIME out of range 1..63");
    end

    localparam logic [TIMER_W-1:0] MG_LOAD = to_timer(MG_MIN);
    localparam logic [TIMER_W-1:0] CG_LOAD = to_timer(CG_MAX);
    localparam logic [TIMER_W-1:0] Y_LOAD  = to_timer(Y_TIME);
    // CG may end early once remain has counted down to this value, which is
    // reached after CG_MIN ticks in country green
    localparam logic [TIMER_W-1:0] CG_EXIT = to_timer(CG_MAX - CG_MIN + 1);

    logic               tick_i_s;
    logic               car_meta_r;
    logic               car_sync_r;
    phase_e             state_r;
    logic [TIMER_W-1:0] remain_r;
    logic               tick_r;
    logic               last_s;
    logic               exit_s;
    phase_e             next_s;
    logic [TIMER_W-1:0] load_s;

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .hold   (bus.hold),
        .tick_i (tick_i_s)
    );

    // Two-flop synchroniser for the asynchronous vehicle sensor
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            car_meta_r <= 1'b0;
            car_sync_r <= 1'b0;
        end else begin
            car_meta_r <= bus.c_car;
            car_sync_r <= car_meta_r;
        end
    end

    // Exit condition and load value for the current phase
    always_comb begin
        last_s = (remain_r <= TIMER_W'(1));
        exit_s = 1'b0;
        load_s = MG_LOAD;
        next_s = next_phase(state_r);
        case (state_r)
            ST_MG: begin
                exit_s = last_s && car_sync_r;
                load_s = Y_LOAD;
            end
            ST_MY: begin
                exit_s = last_s;
                load_s = CG_LOAD;
            end
            ST_CG: begin
                exit_s = last_s || (!car_sync_r && (remain_r <= CG_EXIT));
                load_s = Y_LOAD;
            end
            ST_CY: begin
                exit_s = last_s;
                load_s = MG_LOAD;
            end
            default: begin
                exit_s = 1'b0;
                load_s = MG_LOAD;
            end
        endcase
    end

    // Phase FSM; advances only on ticks, so hold freezes it via the prescaler.
    // tick_r rises on the same edge that updates state and remain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_MG;
            remain_r <= MG_LOAD;
            tick_r   <= 1'b0;
        end else begin
            tick_r <= tick_i_s;
            if (tick_i_s) begin
                if (exit_s) begin
                    state_r  <= next_s;
                    remain_r <= load_s;
                end else if (remain_r > TIMER_W'(1)) begin
                    remain_r <= remain_r - TIMER_W'(1);
                end else begin
                    // MG with no car parks here at 0 until a car arrives
                    remain_r <= {TIMER_W{1'b0}};
                end
            end
        end
    end

    assign bus.current_state = state_r;
    assign bus.remain        = remain_r;
    assign bus.tick          = tick_r;

endmodule

// File: doc/traffic_sequencer.md
# traffic_sequencer

Phase sequencer for the main-road / country-road intersection. Generates the 2-bit `current_state` code consumed by the light decoder, using a 1 s tick derived from `clk` and a country-road vehicle sensor. Main road stays green until a country car is waiting and a minimum green time has elapsed. Country green ends at a maximum time, or earlier once the road clears.

## Interface
Parameters:
- TICK_DIV, 50_000_000, clk cycles per tick (≥2)
- MG_MIN, 20, main-green minimum, ticks
- CG_MAX, 15, country-green maximum, ticks
- CG_MIN, 5, country-green minimum before early exit, ticks
- Y_TIME, 3, yellow duration (both roads), ticks
- Legal ranges: all durations 1..63; CG_MIN ≤ CG_MAX.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- c_car  in  1  country-road vehicle sensor; asynchronous, level
- hold  in  1  synchronous freeze (maintenance)
- current_state  out  2  phase: 0 = MG, 1 = MY, 2 = CG, 3 = CY
- remain  out  6  ticks left in the phase; 0 = MG waiting for a car
- tick  out  1  one-cycle pulse per tick

## Operation
- **Sensor synchroniser:** `c_car` passes through a 2-flop synchroniser to give `car_s`. Pulses shorter than 2 clk may be missed.
- **Prescaler:**
  - Counts 0..TICK_DIV-1 while `hold` = 0.
  - Internal `tick_i` = (cnt == TICK_DIV-1) && !hold; cnt wraps to 0 on that cycle.
  - `hold` = 1 freezes cnt at its current value; counting resumes from that value on release.
- **Phase FSM:** evaluated only on `tick_i` edges. At each tick, in phase P:
  - If P's exit condition is true: move to the next phase and load `remain` with that phase's duration.
  - Otherwise, if remain > 1: remain − 1.
  - Otherwise: remain = 0 (hold the phase).
- **Exit conditions and next phase:**
  - MG: remain ≤ 1 && car_s → MY, load Y_TIME.
  - MY: remain ≤ 1 → CG, load CG_MAX.
  - CG: remain ≤ 1, or (!car_s && remain ≤ CG_MAX − CG_MIN + 1) → CY, load Y_TIME.
  - CY: remain ≤ 1 → MG, load MG_MIN.
- **Resulting phase lengths:**
  - MY and CY last exactly Y_TIME ticks.
  - CG lasts between CG_MIN and CG_MAX ticks.
  - MG lasts at least MG_MIN ticks.
- `car_s` changes during MY or CY have no effect.
- `hold` also freezes `current_state` and `remain`.

## Timing
- **Reset values:** current_state = 0, remain = MG_MIN, tick = 0, prescaler cnt = 0, synchroniser flops = 0. Reset acts immediately, including mid-phase.
- All outputs are registered.
- `tick` goes high on the same edge that updates `current_state` and `remain`, so new values and the tick pulse are visible in the same cycle.
- **First tick after reset:** TICK_DIV clk after reset deassertion.
- **Sensor latency:** from a `c_car` edge, 2 clk to `car_s`, plus the wait until the next tick.
- Simultaneous `hold` and terminal prescaler count: `hold` wins, no tick.

## Structure
- Package `traffic_pkg`:
  - Phase constants ST_MG = 2'd0, ST_MY = 2'd1, ST_CG = 2'd2, ST_CY = 2'd3. The light decoder uses the same constants.
  - TIMER_W = 6.
- Sub-module `tick_gen`: prescaler with inputs clk, rst_n, hold and output tick_i, parameter TICK_DIV.
- Synchroniser and FSM are inline.
- Parameter legality is checked with elaboration-time assertions.

## Test plan
All scenarios use TICK_DIV = 4, MG_MIN = 3, CG_MAX = 4, CG_MIN = 2, Y_TIME = 2.
1. **Reset, no car:** after reset, state 0, remain 3, tick 0. With c_car = 0, remain steps 3→2→1→0 over 3 ticks, then stays 0 and state stays 0 for 10 further ticks.
2. **Car held from reset:** MG for 3 ticks → MY (remain 2) for 2 ticks → CG (remain 4) for 4 ticks → CY for 2 ticks → MG (remain 3). Full cycle = 11 ticks = 44 clk.
3. **Early CG exit:** car drops at CG entry; remain 4→3 at CG tick 1, CY at tick 2 (CG lasted 2 ticks).
4. **Late car:** MG idle at remain 0 for 5 ticks, then c_car = 1. MY entered on the first tick ≥ 2 clk after the c_car edge, with remain 2.
5. **Hold:** assert `hold` for 20 clk mid-CY. state, remain and cnt are frozen and tick = 0. After release, the next tick arrives after the remaining prescaler count.
6. **Async reset mid-CG:** pull rst_n low between edges. state = 0, remain = 3, tick = 0 immediately. After release, the first tick follows 4 clk later.
